// File: rtl/uart_byte_stream_bridge_pkg.sv
// uart_pkg: shared constants, byte type and TX handshake states for the UART byte stream bridge
package uart_pkg;
   localparam int UART_CLK_FREQ = 50_000_000;
   localparam int UART_BAUD_RATE = 115_200;
   typedef logic [7:0] byte_t;
   typedef enum logic [1:0] {IDLE, REQ, REL} tx_state_t;
endpackage

// File: rtl/uart_byte_stream_bridge_if.sv
// uart_byte_stream_bridge_if: stream-side and transceiver-side signals of the bridge
interface uart_byte_stream_bridge_if #(
   parameter int ADDR_W = 4
);
   import uart_pkg::*;
   byte_t s_tx_data;
   logic s_tx_valid;
   logic s_tx_ready;
   byte_t m_rx_data;
   logic m_rx_valid;
   logic m_rx_ready;
   logic [ADDR_W:0] tx_level;
   logic [ADDR_W:0] rx_level;
   logic rx_overflow;
   logic rx_ovf_clr;
   byte_t u_tx_data;
   logic u_tx_data_en;
   logic u_tx_busy;
   byte_t u_rx_data;
   logic u_rx_data_en;
   modport master (
      input s_tx_data, s_tx_valid, m_rx_ready, rx_ovf_clr, u_tx_busy, u_rx_data, u_rx_data_en,
      output s_tx_ready, m_rx_data, m_rx_valid, tx_level, rx_level, rx_overflow, u_tx_data, u_tx_data_en
   );
   modport slave (
      output s_tx_data, s_tx_valid, m_rx_ready, rx_ovf_clr, u_tx_busy, u_rx_data, u_rx_data_en,
      input s_tx_ready, m_rx_data, m_rx_valid, tx_level, rx_level, rx_overflow, u_tx_data, u_tx_data_en
   );
endinterface

// File: rtl/uart_byte_stream_bridge_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO; a push while full is taken only when a pop frees a slot
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input logic clk,
   input logic rst_n,
   input logic push,
   input logic [DATA_W-1:0] push_data,
   input logic pop,
   output logic [DATA_W-1:0] pop_data,
   output logic full,
   output logic empty,
   output logic [ADDR_W:0] level
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
   end
   // level never exceeds 2**ADDR_W, so its MSB alone marks full
   assign full = level[ADDR_W];
   assign empty = level == '0;
   assign pop_data = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         wr_ptr <= wr_ptr + ADDR_W'(do_push);
         rd_ptr <= rd_ptr + ADDR_W'(do_pop);
         level <= level + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
      end
endmodule

// File: rtl/uart_byte_stream_bridge.sv
// uart_byte_stream_bridge: FIFO-buffered valid/ready streams around the UART transceiver request/busy handshake
module uart_byte_stream_bridge
   import uart_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input logic clk,
   input logic rst_n,
   uart_byte_stream_bridge_if.master bus
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   tx_state_t state, state_nx;
   byte_t tx_head, tx_data, data_nx;
   logic [TW-1:0] timer, timer_nx;
   logic tx_full, tx_empty, tx_pop, held, held_nx;
   logic rx_full, rx_empty, rx_pop, rx_overflow;
   sync_fifo #(.DATA_W(8), .ADDR_W(ADDR_W)) u_tx_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(bus.s_tx_valid && bus.s_tx_ready),
      .push_data(bus.s_tx_data),
      .pop(tx_pop),
      .pop_data(tx_head),
      .full(tx_full),
      .empty(tx_empty),
      .level(bus.tx_level)
   );
   sync_fifo #(.DATA_W(8), .ADDR_W(ADDR_W)) u_rx_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(bus.u_rx_data_en),
      .push_data(bus.u_rx_data),
      .pop(rx_pop),
      .pop_data(bus.m_rx_data),
      .full(rx_full),
      .empty(rx_empty),
      .level(bus.rx_level)
   );
   assign bus.s_tx_ready = !tx_full;
   assign bus.m_rx_valid = !rx_empty;
   assign rx_pop = bus.m_rx_valid && bus.m_rx_ready;
   assign bus.rx_overflow = rx_overflow;
   assign bus.u_tx_data = tx_data;
   assign bus.u_tx_data_en = state == REQ;
   // held marks a loaded byte not yet acknowledged by busy, so a timeout retries it without popping
   always_comb begin
      state_nx = state;
      data_nx = tx_data;
      held_nx = held;
      timer_nx = '0;
      tx_pop = 1'b0;
      case (state)
         IDLE:
            if (!bus.u_tx_busy && (held || !tx_empty)) begin
               state_nx = REQ;
               tx_pop = !held;
               held_nx = 1'b1;
               data_nx = held ? tx_data : tx_head;
            end
         REQ:
            if (bus.u_tx_busy) begin
               state_nx = REL;
               held_nx = 1'b0;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) state_nx = IDLE;
            else timer_nx = timer + 1'b1;
         REL:
            if (!bus.u_tx_busy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         tx_data <= '0;
         held <= 1'b0;
         timer <= '0;
         rx_overflow <= 1'b0;
      end else begin
         state <= state_nx;
         tx_data <= data_nx;
         held <= held_nx;
         timer <= timer_nx;
         rx_overflow <= (bus.u_rx_data_en && rx_full && !rx_pop) || (rx_overflow && !bus.rx_ovf_clr);
      end
endmodule

// File: tb/tb_uart_byte_stream_bridge.sv
// tb_uart_byte_stream_bridge: directed, table-driven and randomized checks with a behavioural transceiver and FIFO model
module tb_uart_byte_stream_bridge;
   import uart_pkg::*;
   localparam int BIT_CLKS = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stub = 1'b0;
   always #5 clk = ~clk;
   uart_byte_stream_bridge_if #(.ADDR_W(4)) bus ();
   uart_byte_stream_bridge #(.ADDR_W(4), .ACK_TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_tests = 0;
   int n_fail = 0;
   int peak = 0;
   logic en_q = 1'b0, pend = 1'b0, xbusy = 1'b0, tx_line = 1'b1;
   logic [9:0] frame = '0;
   int cyc = 0;
   byte_t sent_q[$];
   logic [8:0] line_q[$];
   assign bus.u_tx_busy = xbusy && !stub;
   // transceiver: busy two cycles after a request edge, then start, 8 data bits LSB first, stop
   always @(posedge clk)
      if (!rst_n) begin
         en_q <= 1'b0;
         pend <= 1'b0;
         xbusy <= 1'b0;
         tx_line <= 1'b1;
      end else begin
         en_q <= bus.u_tx_data_en;
         pend <= bus.u_tx_data_en && !en_q && !xbusy && !stub;
         if (pend) begin
            xbusy <= 1'b1;
            frame <= {1'b1, bus.u_tx_data, 1'b0};
            cyc <= 0;
            sent_q.push_back(bus.u_tx_data);
         end else if (xbusy) begin
            if (cyc == 10 * BIT_CLKS) begin
               xbusy <= 1'b0;
               tx_line <= 1'b1;
            end else begin
               tx_line <= frame[4'(cyc / BIT_CLKS)];
               cyc <= cyc + 1;
            end
         end
      end
   // line decoder: samples mid-bit and records {stop, data}
   always begin
      logic [7:0] lb;
      @(negedge tx_line);
      repeat (BIT_CLKS / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT_CLKS) @(posedge clk);
         lb[i] = tx_line;
      end
      repeat (BIT_CLKS) @(posedge clk);
      line_q.push_back({tx_line, lb});
   end
   initial begin
      #500_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic wait_sent(input string name, input int n, input int budget);
      int c = 0;
      while (c < budget && !(sent_q.size() >= n && !bus.u_tx_busy && !bus.u_tx_data_en)) begin
         @(negedge clk);
         c++;
         if (int'(bus.tx_level) > peak) peak = int'(bus.tx_level);
      end
      check(name, 32'(c < budget), 32'd1);
   endtask
   typedef struct {
      logic rx_en;
      byte_t rx_data;
      logic rdy;
      logic clr;
      logic e_valid;
      byte_t e_data;
      int e_level;
      logic e_ovf;
   } rx_vec_t;
   rx_vec_t vec[6];
   initial begin
      int n;
      int sz;
      logic pop_m, ovf_m, pulse, rdy, clr;
      byte_t d;
      byte_t got[$];
      byte_t exp_q[$];
      byte_t rq[$];
      vec[0] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h61, 16, 1'b0};
      vec[1] = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 8'h61, 16, 1'b1};
      vec[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h61, 16, 1'b0};
      vec[3] = '{1'b1, 8'h79, 1'b0, 1'b1, 1'b1, 8'h61, 16, 1'b1};
      vec[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h61, 16, 1'b0};
      vec[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h62, 15, 1'b0};
      bus.s_tx_data = '0;
      bus.s_tx_valid = 1'b0;
      bus.m_rx_ready = 1'b0;
      bus.rx_ovf_clr = 1'b0;
      bus.u_rx_data = '0;
      bus.u_rx_data_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tx_level", 32'(bus.tx_level), 32'd0);
      check("rst_rx_level", 32'(bus.rx_level), 32'd0);
      check("rst_s_tx_ready", 32'(bus.s_tx_ready), 32'd1);
      check("rst_m_rx_valid", 32'(bus.m_rx_valid), 32'd0);
      check("rst_u_tx_data", 32'(bus.u_tx_data), 32'd0);
      check("rst_u_tx_data_en", 32'(bus.u_tx_data_en), 32'd0);
      check("rst_rx_overflow", 32'(bus.rx_overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      // single byte: request rises two cycles after the push
      bus.s_tx_data = 8'h55;
      bus.s_tx_valid = 1'b1;
      @(negedge clk);
      bus.s_tx_valid = 1'b0;
      check("t1_en_lat1", 32'(bus.u_tx_data_en), 32'd0);
      @(negedge clk);
      check("t1_en_lat2", 32'(bus.u_tx_data_en), 32'd1);
      check("t1_u_tx_data", 32'(bus.u_tx_data), 32'h55);
      check("t1_tx_level", 32'(bus.tx_level), 32'd0);
      wait_sent("t1_done", 1, 200);
      repeat (4) @(negedge clk);
      check("t1_line_frames", 32'(line_q.size()), 32'd1);
      check("t1_line", 32'(line_q.size() > 0 ? line_q[0] : 9'h0), 32'h155);
      // burst of 16 bytes
      sent_q.delete();
      peak = 0;
      for (int i = 0; i < 16; i++) begin
         check("t2_ready", 32'(bus.s_tx_ready), 32'd1);
         bus.s_tx_data = 8'(i + 1);
         bus.s_tx_valid = 1'b1;
         @(negedge clk);
         if (int'(bus.tx_level) > peak) peak = int'(bus.tx_level);
      end
      bus.s_tx_valid = 1'b0;
      wait_sent("t2_done", 16, 2000);
      check("t2_peak_level", 32'(peak), 32'd15);
      check("t2_count", 32'(sent_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < sent_q.size(); i++) check("t2_order", 32'(sent_q[i]), 32'(i + 1));
      // no acknowledge: timeout and retry of the same byte
      sent_q.delete();
      stub = 1'b1;
      @(negedge clk);
      bus.s_tx_data = 8'hA5;
      bus.s_tx_valid = 1'b1;
      @(negedge clk);
      bus.s_tx_valid = 1'b0;
      n = 0;
      while (!bus.u_tx_data_en && n < 10) begin @(negedge clk); n++; end
      check("t3_rise", 32'(bus.u_tx_data_en), 32'd1);
      n = 0;
      while (bus.u_tx_data_en && n < 20) begin @(negedge clk); n++; end
      check("t3_high_cycles", 32'(n), 32'd8);
      n = 0;
      while (!bus.u_tx_data_en && n < 20) begin @(negedge clk); n++; end
      check("t3_low_cycles", 32'(n), 32'd1);
      check("t3_u_tx_data", 32'(bus.u_tx_data), 32'hA5);
      check("t3_tx_level", 32'(bus.tx_level), 32'd0);
      stub = 1'b0;
      wait_sent("t3_done", 1, 200);
      check("t3_sent_once", 32'(sent_q.size()), 32'd1);
      check("t3_sent_byte", 32'(sent_q.size() > 0 ? sent_q[0] : 8'h0), 32'hA5);
      // RX overflow with consumer stalled
      for (int i = 0; i < 17; i++) begin
         bus.u_rx_data = 8'(8'h20 + i);
         bus.u_rx_data_en = 1'b1;
         @(negedge clk);
      end
      bus.u_rx_data_en = 1'b0;
      check("t4_rx_level", 32'(bus.rx_level), 32'd16);
      check("t4_overflow", 32'(bus.rx_overflow), 32'd1);
      got.delete();
      bus.m_rx_ready = 1'b1;
      for (int i = 0; i < 40 && bus.m_rx_valid; i++) begin
         got.push_back(bus.m_rx_data);
         @(negedge clk);
      end
      bus.m_rx_ready = 1'b0;
      check("t4_drain_count", 32'(got.size()), 32'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) check("t4_drain_data", 32'(got[i]), 32'(8'h20 + i));
      check("t4_ovf_sticky", 32'(bus.rx_overflow), 32'd1);
      bus.rx_ovf_clr = 1'b1;
      @(negedge clk);
      bus.rx_ovf_clr = 1'b0;
      check("t4_ovf_clr", 32'(bus.rx_overflow), 32'd0);
      // full RX FIFO corner cases from the vector table
      for (int i = 0; i < 16; i++) begin
         bus.u_rx_data = 8'(8'h60 + i);
         bus.u_rx_data_en = 1'b1;
         @(negedge clk);
      end
      foreach (vec[i]) begin
         bus.u_rx_data_en = vec[i].rx_en;
         bus.u_rx_data = vec[i].rx_data;
         bus.m_rx_ready = vec[i].rdy;
         bus.rx_ovf_clr = vec[i].clr;
         @(negedge clk);
         check($sformatf("t5_valid[%0d]", i), 32'(bus.m_rx_valid), 32'(vec[i].e_valid));
         check($sformatf("t5_data[%0d]", i), 32'(bus.m_rx_data), 32'(vec[i].e_data));
         check($sformatf("t5_level[%0d]", i), 32'(bus.rx_level), 32'(vec[i].e_level));
         check($sformatf("t5_ovf[%0d]", i), 32'(bus.rx_overflow), 32'(vec[i].e_ovf));
      end
      bus.u_rx_data_en = 1'b0;
      bus.rx_ovf_clr = 1'b0;
      got.delete();
      bus.m_rx_ready = 1'b1;
      for (int i = 0; i < 40 && bus.m_rx_valid; i++) begin
         got.push_back(bus.m_rx_data);
         @(negedge clk);
      end
      bus.m_rx_ready = 1'b0;
      check("t5_drain_count", 32'(got.size()), 32'd15);
      check("t5_last_byte", 32'(got.size() > 0 ? got[got.size() - 1] : 8'h0), 32'h77);
      // randomized RX traffic against a queue model
      ovf_m = bus.rx_overflow;
      for (int c = 0; c < 400; c++) begin
         check("rrx_valid", 32'(bus.m_rx_valid), 32'(rq.size() != 0));
         check("rrx_level", 32'(bus.rx_level), 32'(rq.size()));
         check("rrx_ovf", 32'(bus.rx_overflow), 32'(ovf_m));
         if (rq.size() != 0) check("rrx_data", 32'(bus.m_rx_data), 32'(rq[0]));
         pulse = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         rdy = $urandom_range(0, 2) == 0;
         clr = $urandom_range(0, 15) == 0;
         bus.u_rx_data_en = pulse;
         bus.u_rx_data = d;
         bus.m_rx_ready = rdy;
         bus.rx_ovf_clr = clr;
         sz = rq.size();
         pop_m = rdy && sz > 0;
         if (pop_m) void'(rq.pop_front());
         if (pulse && (sz < 16 || pop_m)) rq.push_back(d);
         ovf_m = (pulse && sz == 16 && !pop_m) || (ovf_m && !clr);
         @(negedge clk);
      end
      bus.u_rx_data_en = 1'b0;
      bus.m_rx_ready = 1'b0;
      bus.rx_ovf_clr = 1'b0;
      // randomized TX traffic: bytes must leave in push order, none lost or repeated
      sent_q.delete();
      exp_q.delete();
      for (int c = 0; c < 3000 && exp_q.size() < 24; c++) begin
         bus.s_tx_valid = 1'($urandom_range(0, 1));
         bus.s_tx_data = 8'($urandom);
         if (bus.s_tx_valid && bus.s_tx_ready) exp_q.push_back(bus.s_tx_data);
         @(negedge clk);
      end
      bus.s_tx_valid = 1'b0;
      wait_sent("rtx_done", exp_q.size(), 3000);
      check("rtx_count", 32'(sent_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) check("rtx_order", 32'(sent_q[i]), 32'(exp_q[i]));
      // reset while requesting with bytes queued
      stub = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.s_tx_data = 8'(8'hC0 + i);
         bus.s_tx_valid = 1'b1;
         @(negedge clk);
      end
      bus.s_tx_valid = 1'b0;
      n = 0;
      while (!bus.u_tx_data_en && n < 10) begin @(negedge clk); n++; end
      check("t6_req", 32'(bus.u_tx_data_en), 32'd1);
      check("t6_queued", 32'(bus.tx_level), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_en", 32'(bus.u_tx_data_en), 32'd0);
      check("t6_tx_level", 32'(bus.tx_level), 32'd0);
      check("t6_ready", 32'(bus.s_tx_ready), 32'd1);
      check("t6_idle", 32'(dut.state == IDLE), 32'd1);
      stub = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_stays_idle", 32'(bus.u_tx_data_en), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_byte_stream_bridge.md
Name: uart_byte_stream_bridge

Overview:
Stream-side adapter that sits directly upstream and downstream of the UART byte transceiver. It buffers outgoing bytes in a TX FIFO and plays the transceiver's edge-triggered `tx_data_en` / `tx_busy` handshake. It also captures the transceiver's single-cycle `rx_data_en` pulses into an RX FIFO. Both FIFOs are exposed to the rest of the design as valid/ready byte streams.

Parameters:
- ADDR_W, 4, FIFO address width; each FIFO holds 2**ADDR_W bytes.
- ACK_TIMEOUT, 8, cycles to wait for `u_tx_busy` after raising `u_tx_data_en` before retrying.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- s_tx_data  in  8  byte to transmit
- s_tx_valid  in  1  s_tx_data valid
- s_tx_ready  out  1  TX FIFO not full
- m_rx_data  out  8  head of RX FIFO (first-word fall-through)
- m_rx_valid  out  1  RX FIFO not empty
- m_rx_ready  in  1  consumer accepts m_rx_data
- tx_level  out  ADDR_W+1  TX FIFO occupancy
- rx_level  out  ADDR_W+1  RX FIFO occupancy
- rx_overflow  out  1  sticky: an RX byte was dropped
- rx_ovf_clr  in  1  clears rx_overflow
- u_tx_data  out  8  byte to transceiver
- u_tx_data_en  out  1  transmit request level (transceiver detects its rising edge)
- u_tx_busy  in  1  transceiver frame in progress
- u_rx_data  in  8  received byte
- u_rx_data_en  in  1  one-cycle pulse, u_rx_data valid

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- State after reset:
  - Both FIFOs are empty, so levels are 0, s_tx_ready=1 and m_rx_valid=0.
  - u_tx_data=0, u_tx_data_en=0, rx_overflow=0, TX FSM in IDLE.
  - Reset mid-frame drops any held byte; the transceiver is reset by the same rst_n.
- FIFO common rules:
  - Push on valid&ready (TX) or on the u_rx_data_en pulse (RX). Pop on FSM load (TX) or m_rx_valid&m_rx_ready (RX).
  - Pointers are ADDR_W bits and wrap modulo 2**ADDR_W. Level is ADDR_W+1 bits, from 0 to 2**ADDR_W.
  - Push and pop in the same cycle leaves the level unchanged.
  - A write into an empty FIFO is visible at the output on the next cycle.
- TX FIFO: s_tx_ready = (tx_level != 2**ADDR_W). A push while full cannot occur.
- RX FIFO:
  - u_rx_data_en while full and not popping: byte dropped, rx_overflow set the next cycle.
  - u_rx_data_en while full and popping in the same cycle: byte accepted.
  - rx_ovf_clr clears rx_overflow. A coincident overflow wins (flag stays 1).
- TX FSM states: IDLE, REQ, REL.
  - IDLE → REQ when the TX FIFO is not empty and u_tx_busy=0.
    - Registers the FIFO head into u_tx_data and pops it.
    - u_tx_data_en=1 from the next cycle.
  - REQ holds u_tx_data_en=1 and u_tx_data stable.
    - On u_tx_busy=1 → REL.
    - If no busy within ACK_TIMEOUT cycles → IDLE with u_tx_data_en=0, retrying the same held byte (no second pop).
  - REL drives u_tx_data_en=0 and holds u_tx_data. It goes → IDLE once u_tx_busy=0.
  - u_tx_data_en is therefore low for at least one cycle between requests. A rising edge is never issued while u_tx_busy=1.
- Latency:
  - Byte pushed into an empty TX FIFO with the transceiver idle: u_tx_data_en rises 2 cycles after the push.
  - Transceiver busy expected 2 cycles after u_tx_data_en rises.
- Back-to-back: the next byte loads in the first IDLE cycle after u_tx_busy falls. No byte is reordered or duplicated.

Decomposition:
- Shared package uart_pkg holds:
  - UART_CLK_FREQ and UART_BAUD_RATE.
  - byte_t (logic [7:0]).
  - The TX FSM state enum {IDLE, REQ, REL}.
- One natural sub-module, sync_fifo (params DATA_W, ADDR_W; push/pop/full/empty/level; FWFT read), instantiated twice.

Test Plan:
1. After reset, push 0x55 with the transceiver idle → u_tx_data_en rises 2 cycles later with u_tx_data=0x55. Transceiver line shows start, 10101010 LSB-first, stop; tx_level returns 0.
2. Push 0x01..0x10 (16 bytes) in consecutive cycles with transceiver attached → s_tx_ready stays 1. Peak tx_level is 15 (one byte already loaded); bytes go out in order 0x01..0x10, each after the previous frame's busy falls.
3. Stub u_tx_busy stuck at 0, push 0xA5 → u_tx_data_en high for 8 cycles, low 1 cycle, high again with u_tx_data=0xA5. tx_level stays 0 (no second pop).
4. Inject 17 u_rx_data_en pulses (0x20..0x30) with m_rx_ready=0 → rx_level=16 and rx_overflow=1. Drain yields 0x20..0x2F; rx_ovf_clr then clears the flag.
5. RX FIFO full, m_rx_ready=1 coincident with a u_rx_data_en pulse of 0x77 → rx_level stays 16, rx_overflow stays 0, 0x77 is the last byte drained.
6. rst_n low for 1 cycle while in REQ with 3 bytes queued → next cycle: u_tx_data_en=0, tx_level=0, s_tx_ready=1, FSM IDLE.
